// File: rtl/arm_mainfsm_pkg.sv
// arm_mainfsm_pkg: state codes, opcode and select encodings, control word for the main FSM
package arm_mainfsm_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNKNOWN  = 4'd10
   } state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [1:0] SRCA_REG = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
   } ctl_t;

endpackage

// File: rtl/arm_mainfsm_outdec.sv
// arm_mainfsm_outdec: Moore output decode, state (and MemReady when ARM_MAINFSM_MEMWAIT_EN) to control word
module arm_mainfsm_outdec
   import arm_mainfsm_pkg::*;
(
   input  logic [3:0] state_i,
`ifdef ARM_MAINFSM_MEMWAIT_EN
   input  logic       mem_ready_i,
`endif
   output ctl_t       ctl_o
);

   logic rdy;
`ifdef ARM_MAINFSM_MEMWAIT_EN
   assign rdy = mem_ready_i;
`else
   assign rdy = 1'b1;
`endif

   // per-state control word; illegal codes fall through to all-zero like UNKNOWN
   always_comb begin
      ctl_o = '0;
      case (state_i)
         FETCH: begin
            ctl_o.ir_write   = rdy;
            ctl_o.next_pc    = rdy;
            ctl_o.alu_src_a  = SRCA_PC;
            ctl_o.alu_src_b  = SRCB_FOUR;
            ctl_o.result_src = RES_ALU;
         end
         DECODE: begin
            ctl_o.alu_src_a  = SRCA_PC;
            ctl_o.alu_src_b  = SRCB_FOUR;
            ctl_o.result_src = RES_ALU;
         end
         MEMADR:   ctl_o.alu_src_b = SRCB_IMM;
         MEMRD:    ctl_o.adr_src = 1'b1;
         MEMWB: begin
            ctl_o.result_src = RES_DATA;
            ctl_o.reg_w      = 1'b1;
         end
         MEMWR: begin
            ctl_o.adr_src = 1'b1;
            ctl_o.mem_w   = 1'b1;
         end
         EXECUTER: ctl_o.alu_op = 1'b1;
         EXECUTEI: begin
            ctl_o.alu_src_b = SRCB_IMM;
            ctl_o.alu_op    = 1'b1;
         end
         ALUWB:    ctl_o.reg_w = 1'b1;
         BRANCH: begin
            ctl_o.alu_src_b  = SRCB_IMM;
            ctl_o.result_src = RES_ALU;
            ctl_o.branch     = 1'b1;
         end
         default:  ctl_o = '0;
      endcase
   end

endmodule

// File: rtl/arm_mainfsm.sv
// arm_mainfsm: multicycle ARM main control FSM; ARM_MAINFSM_MEMWAIT_EN adds MemReady wait states
module arm_mainfsm
   import arm_mainfsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
`ifdef ARM_MAINFSM_MEMWAIT_EN
   input  logic       MemReady,
`endif
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic [3:0] State
);

   state_e state_q, state_d;
   ctl_t   ctl;
   logic   rdy;
   logic   unused_funct;

`ifdef ARM_MAINFSM_MEMWAIT_EN
   assign rdy = MemReady;
`else
   assign rdy = 1'b1;
`endif

   assign unused_funct = ^Funct[4:1];

   // next state; only DECODE and MEMADR look at the instruction fields
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = rdy ? DECODE : FETCH;
         DECODE:   state_d = (Op == OP_MEM) ? MEMADR :
                             (Op == OP_DP)  ? (Funct[5] ? EXECUTEI : EXECUTER) :
                             (Op == OP_BR)  ? BRANCH : UNKNOWN;
         MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    state_d = rdy ? MEMWB : MEMRD;
         MEMWR:    state_d = rdy ? FETCH : MEMWR;
         EXECUTER: state_d = ALUWB;
         EXECUTEI: state_d = ALUWB;
         default:  state_d = FETCH;
      endcase
   end

   // state register; reset drops straight back to FETCH, abandoning any instruction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   arm_mainfsm_outdec u_outdec (
      .state_i     (state_q),
`ifdef ARM_MAINFSM_MEMWAIT_EN
      .mem_ready_i (MemReady),
`endif
      .ctl_o       (ctl)
   );

   assign IRWrite   = ctl.ir_write;
   assign AdrSrc    = ctl.adr_src;
   assign ALUSrcA   = ctl.alu_src_a;
   assign ALUSrcB   = ctl.alu_src_b;
   assign ResultSrc = ctl.result_src;
   assign ALUOp     = ctl.alu_op;
   assign NextPC    = ctl.next_pc;
   assign RegW      = ctl.reg_w;
   assign MemW      = ctl.mem_w;
   assign Branch    = ctl.branch;
   assign State     = state_q;

endmodule

// File: tb/tb_arm_mainfsm.sv
// tb_arm_mainfsm: randomized self-checking bench for arm_mainfsm against an instruction-level model
module tb_arm_mainfsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'b0;
   logic       MemReady = 1'b1;
   logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [3:0] State;
   int         n_cmp = 0;
   int         n_err = 0;

   // expected control word per state code:
   // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch}
   logic [12:0] ctl_tab [0:10];
   logic [12:0] ctl_obs;

   assign ctl_obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};

   always #5 clk = ~clk;

   arm_mainfsm dut (
      .clk       (clk),
      .reset     (reset),
      .Op        (Op),
      .Funct     (Funct),
`ifdef ARM_MAINFSM_MEMWAIT_EN
      .MemReady  (MemReady),
`endif
      .IRWrite   (IRWrite),
      .AdrSrc    (AdrSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .ALUOp     (ALUOp),
      .NextPC    (NextPC),
      .RegW      (RegW),
      .MemW      (MemW),
      .Branch    (Branch),
      .State     (State)
   );

   initial begin
      ctl_tab[0]  = 13'b1_0_01_10_10_0_1_0_0_0;
      ctl_tab[1]  = 13'b0_0_01_10_10_0_0_0_0_0;
      ctl_tab[2]  = 13'b0_0_00_01_00_0_0_0_0_0;
      ctl_tab[3]  = 13'b0_1_00_00_00_0_0_0_0_0;
      ctl_tab[4]  = 13'b0_0_00_00_01_0_0_1_0_0;
      ctl_tab[5]  = 13'b0_1_00_00_00_0_0_0_1_0;
      ctl_tab[6]  = 13'b0_0_00_00_00_1_0_0_0_0;
      ctl_tab[7]  = 13'b0_0_00_01_00_1_0_0_0_0;
      ctl_tab[8]  = 13'b0_0_00_00_00_0_0_1_0_0;
      ctl_tab[9]  = 13'b0_0_00_01_10_0_0_0_0_1;
      ctl_tab[10] = 13'b0;
   end

   // walk one instruction from FETCH back to FETCH, checking every cycle against the model
   task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input bit rand_wait, input string tag);
      int          seq[$];
      int          cyc;
      bit          rdy;
      logic [12:0] exp_ctl;
      seq = {0, 1};
      if (op == 2'b01) seq = funct[0] ? {seq, 2, 3, 4} : {seq, 2, 5};
      else if (op == 2'b00) seq = funct[5] ? {seq, 7, 8} : {seq, 6, 8};
      else if (op == 2'b10) seq.push_back(9);
      else seq.push_back(10);
      Op = op;
      Funct = funct;
      cyc = 0;
      foreach (seq[i]) begin
         do begin
            rdy = 1'b1;
`ifdef ARM_MAINFSM_MEMWAIT_EN
            if (rand_wait && (seq[i] == 0 || seq[i] == 3 || seq[i] == 5)) rdy = ($urandom_range(0, 2) != 0);
            MemReady = rdy;
`endif
            #1;
            exp_ctl = ctl_tab[seq[i]];
            if (!rdy && seq[i] == 0) exp_ctl = exp_ctl & ~13'b1_0_00_00_00_0_1_0_0_0;
            n_cmp++;
            if (State !== 4'(seq[i])) begin
               n_err++;
               $display("FAIL %s state cyc%0d: got %0d want %0d", tag, cyc, State, seq[i]);
            end
            n_cmp++;
            if (ctl_obs !== exp_ctl) begin
               n_err++;
               $display("FAIL %s ctl st%0d cyc%0d: got %b want %b", tag, seq[i], cyc, ctl_obs, exp_ctl);
            end
            cyc++;
            @(posedge clk); #1;
         end while (!rdy);
      end
`ifdef ARM_MAINFSM_MEMWAIT_EN
      MemReady = 1'b1;
`endif
   endtask

   task automatic test_reset;
      reset = 1'b0;
      Op = 2'b10;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (State !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", State); end
      n_cmp++;
      if (ctl_obs !== ctl_tab[0]) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl_obs, ctl_tab[0]); end
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (State !== 4'd1) begin n_err++; $display("FAIL reset_release: got %0d want 1", State); end
      @(posedge clk); #1;
      n_cmp++;
      if (State !== 4'd9) begin n_err++; $display("FAIL reset_branch: got %0d want 9", State); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      run_instr(2'b00, 6'b001000, 1'b0, "add_reg");
      run_instr(2'b00, 6'b101001, 1'b0, "add_imm");
      run_instr(2'b01, 6'b011001, 1'b0, "ldr");
      run_instr(2'b01, 6'b011000, 1'b0, "str");
      run_instr(2'b10, 6'b000000, 1'b0, "b");
      run_instr(2'b11, 6'b111111, 1'b0, "undef");
   endtask

   task automatic test_reset_mid;
      Op = 2'b01;
      Funct = 6'b011001;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (State !== 4'd3) begin n_err++; $display("FAIL mid_pre: got %0d want 3", State); end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (State !== 4'd0) begin n_err++; $display("FAIL mid_async: got %0d want 0", State); end
      n_cmp++;
      if (ctl_obs !== ctl_tab[0]) begin n_err++; $display("FAIL mid_ctl: got %b want %b", ctl_obs, ctl_tab[0]); end
      @(posedge clk); #1;
      n_cmp++;
      if (State !== 4'd0 || RegW !== 1'b0) begin n_err++; $display("FAIL mid_hold: got st%0d regw%b want st0 regw0", State, RegW); end
      Op = 2'b10;
      @(negedge clk) reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (State !== 4'd0) begin n_err++; $display("FAIL mid_resync: got %0d want 0", State); end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 60; k++)
         run_instr(2'($urandom_range(0, 3)), 6'($urandom), 1'b1, "rand");
   endtask

   task automatic test_memwait;
`ifdef ARM_MAINFSM_MEMWAIT_EN
      int pulses = 0;
      MemReady = 1'b0;
      Op = 2'b10;
      repeat (3) begin
         #1;
         pulses += int'(NextPC);
         n_cmp++;
         if (State !== 4'd0 || IRWrite !== 1'b0 || NextPC !== 1'b0) begin
            n_err++;
            $display("FAIL wait_fetch: got st%0d ir%b npc%b want st0 ir0 npc0", State, IRWrite, NextPC);
         end
         @(posedge clk); #1;
      end
      MemReady = 1'b1;
      #1;
      pulses += int'(NextPC);
      @(posedge clk); #1;
      pulses += int'(NextPC);
      n_cmp++;
      if (State !== 4'd1 || pulses != 1) begin
         n_err++;
         $display("FAIL wait_release: got st%0d pulses%0d want st1 pulses1", State, pulses);
      end
      repeat (2) @(posedge clk);
      #1;
`endif
   endtask

   initial begin
      test_reset;
      test_directed;
      test_reset_mid;
      test_memwait;
      test_back_to_back;
      test_directed;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/arm_mainfsm.md
# arm_mainfsm

Main control state machine of the multicycle ARM core. Sequences each instruction through fetch, decode, address/execute, memory and writeback steps, and drives the datapath multiplexer selects and the unconditional write enables. `NextPC`, `RegW`, `MemW` and `Branch` feed the conditional-logic block, which gates them with the condition result.

## Interface
- Parameters: none.
- `clk`  input  1  core clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset; asserted while 0.
- `Op`  input  2  instruction bits [27:26]:
  - 00 data-processing
  - 01 memory
  - 10 branch
  - 11 undefined
- `Funct`  input  6  instruction bits [25:20]:
  - [5] is I (immediate).
  - [0] is S for data-processing, or L for memory.
- `MemReady`  input  1  memory handshake; present only with `ARM_MAINFSM_MEMWAIT_EN`.
- `IRWrite`  output  1  instruction register load enable.
- `AdrSrc`  output  1  memory address select: 0 = PC, 1 = ALU result register.
- `ALUSrcA`  output  2  ALU A select: 00 = register A, 01 = PC.
- `ALUSrcB`  output  2  ALU B select: 00 = register B, 01 = ExtImm, 10 = constant 4.
- `ResultSrc`  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- `ALUOp`  output  1  0 = add, 1 = decode from Funct.
- `NextPC`  output  1  unconditional PC write.
- `RegW`  output  1  register write request; gated downstream by the condition result.
- `MemW`  output  1  memory write request; gated downstream by the condition result.
- `Branch`  output  1  branch request; becomes `PCS` downstream.
- `State`  output  4  current state code, for debug.

## Operation
The block is a Moore FSM. All outputs decode combinationally from the state register only. Outputs not listed for a state are 0.

States, codes, asserted outputs and transitions:
- FETCH (0): `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=0, `ResultSrc`=10, `NextPC`=1. Next state: DECODE.
- DECODE (1): `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10. Next state:
  - `Op`=01 -> MEMADR
  - `Op`=00 and `Funct[5]`=0 -> EXECUTER
  - `Op`=00 and `Funct[5]`=1 -> EXECUTEI
  - `Op`=10 -> BRANCH
  - `Op`=11 -> UNKNOWN
- MEMADR (2): `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=0. Next state: MEMRD if `Funct[0]`=1, else MEMWR.
- MEMRD (3): `AdrSrc`=1. Next state: MEMWB.
- MEMWB (4): `ResultSrc`=01, `RegW`=1. Next state: FETCH.
- MEMWR (5): `AdrSrc`=1, `MemW`=1. Next state: FETCH.
- EXECUTER (6): `ALUSrcA`=00, `ALUSrcB`=00, `ALUOp`=1. Next state: ALUWB.
- EXECUTEI (7): `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=1. Next state: ALUWB.
- ALUWB (8): `ResultSrc`=00, `RegW`=1. Next state: FETCH.
- BRANCH (9): `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=0, `ResultSrc`=10, `Branch`=1. Next state: FETCH.
- UNKNOWN (10): all outputs 0. Next state: FETCH. The instruction executes as a no-op.
- Codes 11-15 are illegal. They decode as UNKNOWN: outputs 0, next state FETCH.

`Op` and `Funct` are sampled only in DECODE and MEMADR; they are ignored in all other states.

## Timing
- Reset:
  - The state register goes to FETCH asynchronously when `reset`=0.
  - While in reset, the outputs show FETCH values: `IRWrite`=1, `NextPC`=1, `ALUSrcA`=01, `ALUSrcB`=10, `ResultSrc`=10, all others 0, `State`=0.
  - The first FETCH executes on the first rising edge after `reset` returns to 1.
- Reset mid-instruction abandons the sequence immediately. No partial writeback follows.
- One state per cycle. Cycles per instruction:
  - branch: 3
  - data-processing: 4
  - STR: 4
  - LDR: 5
  - undefined: 3
- `Op` and `Funct` must be stable at the rising edge that leaves DECODE or MEMADR.

## Configuration
- `ARM_MAINFSM_MEMWAIT_EN` defined:
  - The `MemReady` port exists.
  - FETCH, MEMRD and MEMWR hold while `MemReady`=0.
  - In FETCH, `IRWrite` and `NextPC` assert only in the cycle `MemReady`=1, so the PC advances exactly once.
  - In MEMWR, `MemW` stays high throughout the wait.
  - All other outputs keep their state values during a wait.
  - `MemReady` is ignored in every other state.
- `ARM_MAINFSM_MEMWAIT_EN` undefined: no `MemReady` port; behaviour is identical to `MemReady` tied to 1.

## Structure
- Package `arm_mainfsm_pkg`: 4-bit state encoding constants (FETCH..UNKNOWN), `Op` encodings (`OP_DP`=00, `OP_MEM`=01, `OP_BR`=10), and the select encodings for `ALUSrcA`, `ALUSrcB` and `ResultSrc`.
- Sub-module `arm_mainfsm_outdec`: purely combinational, state (plus `MemReady` when the macro is enabled) to control word. The parent module holds the state register and next-state logic.

## Test plan
- Reset: hold `reset`=0 for 2 cycles -> `State`=0, `IRWrite`=1, `NextPC`=1, `RegW`=`MemW`=`Branch`=0. Release -> `State`=1 after one edge.
- ADD register form (`Op`=00, `Funct`=6'b001000) -> states 0,1,6,8,0. `ALUOp`=1 in state 6; `RegW`=1 only in state 8.
- LDR (`Op`=01, `Funct`=6'b011001) -> states 0,1,2,3,4,0. `AdrSrc`=1 in state 3; `ResultSrc`=01 and `RegW`=1 in state 4.
- STR (`Op`=01, `Funct[0]`=0) -> states 0,1,2,5,0. `MemW`=1 only in state 5. B (`Op`=10) -> states 0,1,9,0 with `Branch`=1 in state 9.
- `Op`=11 -> states 0,1,10,0 with all outputs 0 in state 10. Assert `reset` in state 3 -> `State`=0 immediately.
- With `ARM_MAINFSM_MEMWAIT_EN`: `MemReady`=0 for 3 cycles in FETCH -> `State` stays 0 and `IRWrite`=`NextPC`=0. Then `MemReady`=1 -> exactly one `NextPC` pulse, then `State`=1.
